deshiftreg: RTL and testbench

DESHIFTREG -- requirements
Module: deshiftreg

---
 rtl/deshiftreg.sv | 102 ++++++++++
 tb/tb_deshiftreg.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/deshiftreg.sv
// Serial-to-parallel deserializer with a one-word output holder.
// A word appears one cycle after its last bit; with no ack, the next completed word is dropped and overrun_out is set.
module deshiftreg #(
    parameter int WIDTH = 8,
    parameter bit LEFT  = 1'b1
) (
    input  logic                           clock_in,
    input  logic                           reset_in,
    input  logic                           shift_in,
    input  logic                           bit_in,
    input  logic                           clear_in,
    input  logic                           ack_in,
    output logic [WIDTH-1:0]               data_out,
    output logic                           valid_out,
    output logic [$clog2(WIDTH+1)-1:0]     count_out,
    output logic                           overrun_out
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sr, sr_nxt, sr_shift;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] data, data_nxt;
    logic             overrun, overrun_nxt;
    logic             done;

    // The incoming bit is always the one inserted at the entry end of the register.
    always_comb begin
        if (LEFT) begin
            sr_shift = {sr[WIDTH-2:0], bit_in};
        end else begin
            sr_shift = {bit_in, sr[WIDTH-1:1]};
        end
        done = shift_in && (cnt == LAST_CNT);
    end

    always_comb begin
        sr_nxt      = sr;
        cnt_nxt     = cnt;
        state_nxt   = state;
        data_nxt    = data;
        overrun_nxt = overrun;
        if (clear_in) begin
            sr_nxt      = '0;
            cnt_nxt     = '0;
            state_nxt   = EMPTY;
            overrun_nxt = 1'b0;
        end else begin
            if (done) begin
                sr_nxt  = '0;
                cnt_nxt = '0;
            end else if (shift_in) begin
                sr_nxt  = sr_shift;
                cnt_nxt = cnt + CW'(1);
            end
            case (state)
                EMPTY: begin
                    if (done) begin
                        data_nxt  = sr_shift;
                        state_nxt = FULL;
                    end
                end
                FULL: begin
                    if (done && ack_in) begin
                        data_nxt = sr_shift;
                    end else if (done) begin
                        overrun_nxt = 1'b1;
                    end else if (ack_in) begin
                        state_nxt = EMPTY;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            sr      <= '0;
            cnt     <= '0;
            state   <= EMPTY;
            data    <= '0;
            overrun <= 1'b0;
        end else begin
            sr      <= sr_nxt;
            cnt     <= cnt_nxt;
            state   <= state_nxt;
            data    <= data_nxt;
            overrun <= overrun_nxt;
        end
    end

    assign data_out    = data;
    assign valid_out   = (state == FULL);
    assign count_out   = cnt;
    assign overrun_out = overrun;

endmodule

// File: tb/tb_deshiftreg.sv
// Bench for deshiftreg: MSB-first (LEFT=1) and LSB-first (LEFT=0) instances share one stimulus stream.
module tb_deshiftreg;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       shift = 1'b0;
    logic       bitv = 1'b0;
    logic       clr = 1'b0;
    logic       ack = 1'b0;
    logic [7:0] dl, dr;
    logic       vl, vr, ol, orr;
    logic [3:0] cl, cr;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] ql[$];
    logic [7:0] qr[$];

    always #5 clk = ~clk;

    deshiftreg #(.WIDTH(8), .LEFT(1'b1)) dut_l (
        .clock_in(clk), .reset_in(rst), .shift_in(shift), .bit_in(bitv),
        .clear_in(clr), .ack_in(ack), .data_out(dl), .valid_out(vl),
        .count_out(cl), .overrun_out(ol)
    );

    deshiftreg #(.WIDTH(8), .LEFT(1'b0)) dut_r (
        .clock_in(clk), .reset_in(rst), .shift_in(shift), .bit_in(bitv),
        .clear_in(clr), .ack_in(ack), .data_out(dr), .valid_out(vr),
        .count_out(cr), .overrun_out(orr)
    );

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives the word first bit = seq[7]; leaves shift asserted so words can run back to back.
    task automatic shift_word(input logic [7:0] seq, input logic ack_last);
        for (int i = 7; i >= 0; i--) begin
            shift = 1'b1;
            bitv  = seq[i];
            ack   = ack_last && (i == 0);
            step();
        end
        ack = 1'b0;
    endtask

    task automatic idle();
        shift = 1'b0;
        bitv  = 1'b0;
        ack   = 1'b0;
        clr   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        vectors++;
        if ({dl, vl, cl, ol} !== 14'd0 || {dr, vr, cr, orr} !== 14'd0) begin
            miscompares++;
            $display("FAIL reset: left d=%h v=%b c=%0d o=%b right d=%h v=%b c=%0d o=%b, need all 0",
                     dl, vl, cl, ol, dr, vr, cr, orr);
        end
    endtask

    task automatic test_left_right();
        logic [7:0] seq = 8'b1011_0010;
        for (int i = 7; i >= 1; i--) begin
            shift = 1'b1;
            bitv  = seq[i];
            step();
        end
        vectors++;
        if (cl !== 4'd7 || vl !== 1'b0 || dl !== 8'h00 || vr !== 1'b0 || dr !== 8'h00) begin
            miscompares++;
            $display("FAIL pre_completion: cnt=%0d vl=%b dl=%h vr=%b dr=%h, need 7 0 00 0 00",
                     cl, vl, dl, vr, dr);
        end
        ql.push_back(seq);
        qr.push_back(rev8(seq));
        bitv = seq[0];
        step();
        idle();
        vectors++;
        if (vl !== 1'b1 || dl !== ql[0] || cl !== 4'd0) begin
            miscompares++;
            $display("FAIL left_word: d=%h v=%b c=%0d, need %h 1 0", dl, vl, cl, ql[0]);
        end
        vectors++;
        if (vr !== 1'b1 || dr !== qr[0] || cr !== 4'd0) begin
            miscompares++;
            $display("FAIL right_word: d=%h v=%b c=%0d, need %h 1 0", dr, vr, cr, qr[0]);
        end
    endtask

    task automatic test_overrun();
        shift_word(8'hFF, 1'b0);
        idle();
        vectors++;
        if (dl !== ql[0] || vl !== 1'b1 || ol !== 1'b1 || dr !== qr[0] || orr !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun: dl=%h vl=%b ol=%b dr=%h or=%b, need %h 1 1 %h 1",
                     dl, vl, ol, dr, orr, ql[0], qr[0]);
        end
        ack = 1'b1;
        step();
        idle();
        vectors++;
        if (vl !== 1'b0 || dl !== ql[0] || ol !== 1'b1 || vr !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_sticky: vl=%b dl=%h ol=%b vr=%b, need 0 %h 1 0", vl, dl, ol, vr, ql[0]);
        end
        void'(ql.pop_front());
        void'(qr.pop_front());
        ack = 1'b1;
        step();
        idle();
        vectors++;
        if (vl !== 1'b0 || cl !== 4'd0) begin
            miscompares++;
            $display("FAIL ack_empty: v=%b c=%0d, need 0 0", vl, cl);
        end
        clr = 1'b1;
        step();
        idle();
        vectors++;
        if (ol !== 1'b0 || orr !== 1'b0 || dl !== 8'hB2 || dr !== 8'h4D) begin
            miscompares++;
            $display("FAIL clear_flag: ol=%b or=%b dl=%h dr=%h, need 0 0 b2 4d", ol, orr, dl, dr);
        end
    endtask

    task automatic test_ack_same_cycle();
        ql.push_back(8'hB2);
        qr.push_back(rev8(8'hB2));
        shift_word(8'hB2, 1'b0);
        vectors++;
        if (vl !== 1'b1 || dl !== ql[0]) begin
            miscompares++;
            $display("FAIL refill: v=%b d=%h, need 1 %h", vl, dl, ql[0]);
        end
        void'(ql.pop_front());
        void'(qr.pop_front());
        ql.push_back(8'h0F);
        qr.push_back(rev8(8'h0F));
        shift_word(8'h0F, 1'b1);
        idle();
        vectors++;
        if (dl !== ql[0] || vl !== 1'b1 || ol !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_replace_left: d=%h v=%b o=%b, need %h 1 0", dl, vl, ol, ql[0]);
        end
        vectors++;
        if (dr !== qr[0] || vr !== 1'b1 || orr !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_replace_right: d=%h v=%b o=%b, need %h 1 0", dr, vr, orr, qr[0]);
        end
    endtask

    task automatic test_clear();
        logic [7:0] held_l = ql[0];
        logic [7:0] held_r = qr[0];
        for (int i = 0; i < 3; i++) begin
            shift = 1'b1;
            bitv  = 1'b1;
            step();
        end
        vectors++;
        if (cl !== 4'd3) begin
            miscompares++;
            $display("FAIL partial_count: c=%0d, need 3", cl);
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        idle();
        ql.delete();
        qr.delete();
        vectors++;
        if (cl !== 4'd0 || vl !== 1'b0 || ol !== 1'b0 || dl !== held_l || dr !== held_r) begin
            miscompares++;
            $display("FAIL clear: c=%0d v=%b o=%b dl=%h dr=%h, need 0 0 0 %h %h",
                     cl, vl, ol, dl, dr, held_l, held_r);
        end
        step();
        vectors++;
        if (cl !== 4'd0) begin
            miscompares++;
            $display("FAIL idle_hold: c=%0d, need 0", cl);
        end
        ql.push_back(8'h01);
        qr.push_back(rev8(8'h01));
        shift_word(8'h01, 1'b0);
        idle();
        vectors++;
        if (dl !== ql[0] || vl !== 1'b1 || dr !== qr[0]) begin
            miscompares++;
            $display("FAIL after_clear: dl=%h v=%b dr=%h, need %h 1 %h", dl, vl, dr, ql[0], qr[0]);
        end
        ack = 1'b1;
        step();
        idle();
        void'(ql.pop_front());
        void'(qr.pop_front());
    endtask

    task automatic test_back_to_back();
        ql.push_back(8'hA5);
        qr.push_back(rev8(8'hA5));
        shift_word(8'hA5, 1'b0);
        vectors++;
        if (dl !== ql[0] || vl !== 1'b1 || dr !== qr[0]) begin
            miscompares++;
            $display("FAIL b2b_first: dl=%h v=%b dr=%h, need %h 1 %h", dl, vl, dr, ql[0], qr[0]);
        end
        void'(ql.pop_front());
        void'(qr.pop_front());
        ql.push_back(8'h3C);
        qr.push_back(rev8(8'h3C));
        shift_word(8'h3C, 1'b1);
        idle();
        vectors++;
        if (dl !== ql[0] || vl !== 1'b1 || dr !== qr[0] || ol !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_second: dl=%h v=%b dr=%h o=%b, need %h 1 %h 0",
                     dl, vl, dr, ol, ql[0], qr[0]);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            shift = 1'b1;
            bitv  = 1'b1;
            step();
        end
        rst = 1'b1;
        ack = 1'b1;
        step();
        rst = 1'b0;
        idle();
        ql.delete();
        qr.delete();
        vectors++;
        if ({dl, vl, cl, ol} !== 14'd0 || {dr, vr, cr, orr} !== 14'd0) begin
            miscompares++;
            $display("FAIL reset_mid: left d=%h v=%b c=%0d o=%b right d=%h v=%b c=%0d o=%b, need all 0",
                     dl, vl, cl, ol, dr, vr, cr, orr);
        end
        ql.push_back(8'h96);
        qr.push_back(rev8(8'h96));
        shift_word(8'h96, 1'b0);
        idle();
        vectors++;
        if (dl !== ql[0] || vl !== 1'b1 || dr !== qr[0] || cl !== 4'd0) begin
            miscompares++;
            $display("FAIL post_reset_word: dl=%h v=%b dr=%h c=%0d, need %h 1 %h 0",
                     dl, vl, dr, cl, ql[0], qr[0]);
        end
    endtask

    initial begin
        test_reset();
        test_left_right();
        test_overrun();
        test_ack_same_cycle();
        test_clear();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
